address_generator: RTL and testbench
====================================

// Module: address_generator
// PURPOSE
//   Free-running modulo counter that produces byte addresses for a 32-bit-word
//   memory, such as a BRAM playback or acquisition buffer.
//   It counts 0..count_max repeatedly and outputs the count shifted left by 2.
//   The result is a byte address that steps by 4 per clock.
//   It sits between a control register (count_max, sclr) and a RAM address port.
// PARAMETERS
//   COUNT_WIDTH  5  width of the word counter and of count_max; address is COUNT_WIDTH+2 bits
// PORTS
//   clk        in   1              system clock; all state changes on its rising edge
//   resetn     in   1              asynchronous, active-low reset
//   sclr       in   1              synchronous clear, active-high
//   count_max  in   COUNT_WIDTH    last word index of the cycle (inclusive)
//   address    out  COUNT_WIDTH+2  byte address = {count, 2'b00}
// BEHAVIOUR
//   - Interface: one clock (clk); reset is asynchronous and active-low (resetn).
//   - State: count register, COUNT_WIDTH bits, unsigned.
//   - Reset: resetn=0 immediately forces count=0 and address=0, independent of clk.
//     The first increment happens on the first rising edge after resetn goes high.
//   - Each rising clk edge, with resetn=1, in priority order:
//       1. sclr=1: count <= 0.
//       2. else if count >= count_max: count <= 0 (wrap).
//       3. else: count <= count + 1.
//   - address is driven directly from the count register: address = {count, 2'b00}.
//     address[1:0] is always 0.
//     There is no combinational path from any input to address.
//     Latency: 1 clk from sclr or count_max to an address change.
//   - Period: count_max+1 cycles; sequence 0,4,8,...,4*count_max,0,...
//   - count_max=0: address stays 0.
//   - count_max = 2^COUNT_WIDTH-1: full range; natural wrap to 0.
//   - count_max lowered below the current count: wraps to 0 on the next edge (rule 2).
//     The counter never runs past count_max.
//   - count_max is sampled every cycle; no holding register.
//     Callers driving wider values must truncate to COUNT_WIDTH bits themselves
//     (63 on a 5-bit port becomes 31).
//   - sclr held high: address stays 0.
//     Counting restarts from 0 with 4 on the first edge after sclr falls.
//   - sclr and the wrap condition on the same edge: both give 0; no conflict.
//   - resetn asserted mid-count: address is 0 at once and remains 0 while resetn=0.
//   - Inputs are sampled only when resetn=1.
//     X on sclr while resetn=1 is a caller error; the bench drives sclr known from time 0.
// TESTING
//   1. resetn=0 for 3 clk, count_max=31 -> address=0 throughout.
//      Release -> 0,4,8,...,124,0,4 (period 32).
//   2. COUNT_WIDTH=5, count_max=63 (truncated to 31) with a 1-cycle sclr pulse
//      -> address 0 the cycle after, then 4,8,...,124,0; no value above 124.
//   3. count_max=5 -> repeating 0,4,8,12,16,20.
//      Change to 2 while count=4 (address=16) -> next address 0, then 0,4,8,0.
//   4. count_max=0 -> address constant 0.
//      sclr held 5 cycles at count_max=10 -> 0 for all 5; 4 on the first edge after release.
//   5. Pull resetn low asynchronously between edges at address=40
//      -> address=0 before the next edge; counting restarts after release.
//   6. Self-check every cycle against a reference model of rules 1-3; assert address[1:0]==0.

Source files
------------

// File: rtl/address_generator.sv
// address_generator: free-running modulo word counter emitting byte addresses {count, 2'b00}
module address_generator #(
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   sclr,
  input  logic [COUNT_WIDTH-1:0] count_max,
  output logic [COUNT_WIDTH+1:0] address
);
  logic [COUNT_WIDTH-1:0] count;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) count <= '0;
    else count <= (sclr || count >= count_max) ? '0 : count + 1'b1;
  assign address = {count, 2'b00};
endmodule

// File: tb/tb_address_generator.sv
// tb_address_generator: directed vectors plus a per-cycle reference model for address_generator
module tb_address_generator;
  logic       clk = 0;
  logic       resetn = 0;
  logic       sclr = 0;
  logic [4:0] count_max = 5'd31;
  logic [6:0] address;
  logic [4:0] mc = '0;
  int         n_checks = 0;
  int         n_pass = 0;

  address_generator #(.COUNT_WIDTH(5)) dut (
    .clk(clk), .resetn(resetn), .sclr(sclr), .count_max(count_max), .address(address)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic step(input string tag, input logic [6:0] exp);
    mc = !resetn ? 5'd0 : (sclr || mc >= count_max) ? 5'd0 : mc + 5'd1;
    @(posedge clk);
    #1;
    check(tag, address, exp);
    check("model", address, {mc, 2'b00});
    check("lsb", {5'd0, address[1:0]}, 7'd0);
  endtask

  initial begin
    #1;
    check("reset_t0", address, 7'd0);
    for (int i = 0; i < 3; i++) step("reset_hold", 7'd0);
    resetn = 1;
    for (int i = 1; i <= 33; i++) step("full_range", 7'((i % 32) * 4));
    count_max = 5'(6'd63);
    sclr = 1;
    step("trunc_sclr", 7'd0);
    sclr = 0;
    for (int i = 1; i <= 32; i++) begin
      step("trunc_seq", 7'((i % 32) * 4));
      if (address > 7'd124) check("trunc_max", address, 7'd124);
    end
    count_max = 5'd5;
    sclr = 1;
    step("cm5_sclr", 7'd0);
    sclr = 0;
    step("cm5_a", 7'd4);
    step("cm5_b", 7'd8);
    step("cm5_c", 7'd12);
    step("cm5_d", 7'd16);
    step("cm5_e", 7'd20);
    step("cm5_wrap", 7'd0);
    step("cm5_f", 7'd4);
    step("cm5_g", 7'd8);
    step("cm5_h", 7'd12);
    step("cm5_i", 7'd16);
    count_max = 5'd2;
    step("lower_wrap", 7'd0);
    step("cm2_a", 7'd4);
    step("cm2_b", 7'd8);
    step("cm2_wrap", 7'd0);
    count_max = 5'd0;
    for (int i = 0; i < 4; i++) step("cm0", 7'd0);
    count_max = 5'd10;
    sclr = 1;
    for (int i = 0; i < 5; i++) step("sclr_hold", 7'd0);
    sclr = 0;
    step("sclr_release", 7'd4);
    count_max = 5'd31;
    sclr = 1;
    step("pre_rst_sclr", 7'd0);
    sclr = 0;
    for (int i = 1; i <= 10; i++) step("pre_rst", 7'(i * 4));
    #2;
    resetn = 0;
    mc = '0;
    #1;
    check("async_rst", address, 7'd0);
    step("rst_low_a", 7'd0);
    step("rst_low_b", 7'd0);
    resetn = 1;
    step("rst_release_a", 7'd4);
    step("rst_release_b", 7'd8);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
